// File: rtl/signed_divider_4_bit.sv
// Multi-cycle signed divider: 8-bit dividend / 4-bit divisor, truncating toward zero.
// Define DIV_OVF_SAT_EN to saturate q on overflow; otherwise q wraps.
module signed_divider_4_bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] z,
    input  logic [3:0] y,
    output logic       busy,
    output logic       done,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       overflow,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e     state_q, state_d;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [7:0] dvd_q, dvd_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] ymag_q, ymag_d;
    logic       sz_q, sz_d;
    logic       sy_q, sy_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       ovf_q, ovf_d;
    logic       dbz_q, dbz_d;

    logic [4:0] shifted;
    logic [5:0] trial;
    logic       qneg;
    logic [3:0] q_fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            rem_q   <= '0;
            ymag_q  <= '0;
            sz_q    <= 1'b0;
            sy_q    <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            ymag_q  <= ymag_d;
            sz_q    <= sz_d;
            sy_q    <= sy_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        ymag_d  = ymag_q;
        sz_d    = sz_q;
        sy_d    = sy_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        shifted = {rem_q, dvd_q[7]};
        trial   = {1'b0, shifted} - {2'b00, ymag_q};
        qneg    = sz_q ^ sy_q;
        q_fix   = qneg ? (~dvd_q[3:0] + 4'd1) : dvd_q[3:0];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sz_d   = z[7];
                    sy_d   = y[3];
                    dvd_d  = z[7] ? (~z + 8'd1) : z;
                    ymag_d = y[3] ? (~y + 4'd1) : y;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (y == 4'd0) begin
                        q_d     = 4'h0;
                        r_d     = z[3:0];
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // Remainder stays below |y| <= 8, so the low 4 bits of trial always fit.
                if (!trial[5]) begin
                    rem_d = trial[3:0];
                    dvd_d = {dvd_q[6:0], 1'b1};
                end else begin
                    rem_d = shifted[3:0];
                    dvd_d = {dvd_q[6:0], 1'b0};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                ovf_d = qneg ? (dvd_q > 8'd8) : (dvd_q > 8'd7);
`ifdef DIV_OVF_SAT_EN
                if (ovf_d) begin
                    q_d = qneg ? 4'h8 : 4'h7;
                end else begin
                    q_d = q_fix;
                end
`else
                q_d = q_fix;
`endif
                r_d     = sz_q ? (~rem_q + 4'd1) : rem_q;
                dbz_d   = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign q           = q_q;
    assign r           = r_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_divider_4_bit.sv
// Self-checking bench for signed_divider_4_bit: directed table, corner sequences, random vs model.
// Honours DIV_OVF_SAT_EN for the expected overflow quotient.
module tb_signed_divider_4_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] z;
    logic [3:0] y;
    logic       busy, done, overflow, div_by_zero;
    logic [3:0] q, r;

    int n_pass = 0;
    int n_tot  = 0;
    logic [3:0] prev_q = 4'h0;
    logic [3:0] prev_r = 4'h0;

    signed_divider_4_bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .z           (z),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] z;
        logic [3:0] y;
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dbz;
    } vec_t;

`ifdef DIV_OVF_SAT_EN
    localparam logic [3:0] Q80F = 4'h7, Q7F1 = 4'h7, Q801 = 4'h8, Q808 = 4'h7;
`else
    localparam logic [3:0] Q80F = 4'h0, Q7F1 = 4'hF, Q801 = 4'h0, Q808 = 4'h0;
`endif

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: plain integer division (truncates toward zero) and the spec's q/r rules.
    task automatic model(input logic [7:0] tz, input logic [3:0] ty,
                         output logic [3:0] eq, output logic [3:0] er,
                         output logic eo, output logic ed);
        int zi, yi, qt, rt;
        zi = int'($signed(tz));
        yi = int'($signed(ty));
        if (yi == 0) begin
            eq = 4'h0; er = tz[3:0]; eo = 1'b0; ed = 1'b1;
        end else begin
            qt = zi / yi;
            rt = zi - qt * yi;
            eo = (qt > 7) || (qt < -8);
            ed = 1'b0;
            eq = qt[3:0];
`ifdef DIV_OVF_SAT_EN
            if (eo) eq = (qt > 0) ? 4'h7 : 4'h8;
`endif
            er = rt[3:0];
        end
    endtask

    task automatic do_op(input logic [7:0] tz, input logic [3:0] ty,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic eo, input logic ed,
                         input int intrude, input logic pulse_done, input string tag);
        int lat, exp_lat;
        exp_lat = ed ? 1 : 10;
        @(negedge clk);
        z = tz; y = ty; start = 1'b1;
        @(negedge clk);
        start = 1'b0; z = 8'($urandom); y = 4'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            chk($sformatf("%s busy c%0d", tag, lat), {7'd0, busy}, 8'd1);
            chk($sformatf("%s q hold c%0d", tag, lat), {4'd0, q}, {4'd0, prev_q});
            start = (lat == intrude);
            if (start) begin
                z = 8'h71; y = 4'h3;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 8'(lat), 8'(exp_lat));
        chk({tag, " q"}, {4'd0, q}, {4'd0, eq});
        chk({tag, " r"}, {4'd0, r}, {4'd0, er});
        chk({tag, " overflow"}, {7'd0, overflow}, {7'd0, eo});
        chk({tag, " div_by_zero"}, {7'd0, div_by_zero}, {7'd0, ed});
        chk({tag, " busy at done"}, {7'd0, busy}, 8'd1);
        start = pulse_done;
        z = 8'h33; y = 4'h2;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done after"}, {7'd0, done}, 8'd0);
        chk({tag, " busy after"}, {7'd0, busy}, 8'd0);
        prev_q = eq;
        prev_r = er;
    endtask

    vec_t tbl[10];

    initial begin
        logic [3:0] eq, er;
        logic       eo, ed, seen;

        tbl[0] = '{8'h23, 4'h5, 4'h7, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{8'hE9, 4'h4, 4'hB, 4'hD, 1'b0, 1'b0};
        tbl[2] = '{8'h17, 4'hC, 4'hB, 4'h3, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 4'hF, Q80F, 4'h0, 1'b1, 1'b0};
        tbl[4] = '{8'h5A, 4'h0, 4'h0, 4'hA, 1'b0, 1'b1};
        tbl[5] = '{8'h7F, 4'h1, Q7F1, 4'h0, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 4'h1, Q801, 4'h0, 1'b1, 1'b0};
        tbl[7] = '{8'h80, 4'h8, Q808, 4'h0, 1'b1, 1'b0};
        tbl[8] = '{8'hC8, 4'h7, 4'h8, 4'h0, 1'b0, 1'b0};
        tbl[9] = '{8'hF9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; z = 8'h00; y = 4'h0;
        @(negedge clk);
        chk("reset busy", {7'd0, busy}, 8'd0);
        chk("reset done", {7'd0, done}, 8'd0);
        chk("reset q", {4'd0, q}, 8'd0);
        chk("reset r", {4'd0, r}, 8'd0);
        chk("reset overflow", {7'd0, overflow}, 8'd0);
        chk("reset div_by_zero", {7'd0, div_by_zero}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].z, tbl[i].y, tbl[i].q, tbl[i].r, tbl[i].ovf, tbl[i].dbz,
                  0, 1'b1, $sformatf("tbl%0d", i));
        end

        // Second start three cycles into CALC must be ignored.
        do_op(8'h17, 4'h5, 4'h4, 4'h3, 1'b0, 1'b0, 3, 1'b0, "intrude");

        // Reset in CALC cycle 5 aborts; outputs clear immediately.
        @(negedge clk);
        z = 8'h29; y = 4'h6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", {7'd0, busy}, 8'd0);
        chk("abort done", {7'd0, done}, 8'd0);
        chk("abort q", {4'd0, q}, 8'd0);
        chk("abort r", {4'd0, r}, 8'd0);
        chk("abort overflow", {7'd0, overflow}, 8'd0);
        chk("abort div_by_zero", {7'd0, div_by_zero}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_q = 4'h0;
        prev_r = 4'h0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no done after abort", {7'd0, seen}, 8'd0);
        do_op(8'hF1, 4'h3, 4'hB, 4'h0, 1'b0, 1'b0, 0, 1'b0, "post reset");

        for (int i = 0; i < 40; i++) begin
            logic [7:0] rz;
            logic [3:0] ry;
            rz = 8'($urandom);
            ry = 4'($urandom);
            model(rz, ry, eq, er, eo, ed);
            do_op(rz, ry, eq, er, eo, ed, int'($urandom_range(0, 9)), 1'($urandom),
                  $sformatf("rnd%0d z=%0h y=%0h", i, rz, ry));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
